note_playback: RTL and testbench

//  Synthesizable playback engine for recorded buzzer tracks. Reads run-length records {key, length} from a
//  1-cycle-latency record RAM filled by the recorder, and drives one ASCII note per cycle to the buzzer

---
 rtl/beat_pkg.sv | 24 ++
 rtl/note_playback_if.sv | 18 +
 rtl/hold_counter.sv | 35 +++
 rtl/note_playback.sv | 136 +++++++++++++
 tb/tb_note_playback.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared buzzer-track types: record layout, silence key, player/recorder states
package beat_pkg;

    localparam int ADDR_W = 8;
    localparam int KEY_W  = 7;
    localparam int LEN_W  = 16;

    localparam logic [KEY_W-1:0] KEY_SILENCE = '0;

    // One run-length record as stored in the record RAM: {key, len}
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [LEN_W-1:0] len;
    } record_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/note_playback_if.sv
// rtl/note_playback_if.sv - record RAM read port (1-cycle read latency)
// Signals:
//   rd_en    read strobe from the player
//   rd_addr  record index to read
//   rd_data  {key, len}, valid the cycle after rd_en
// Modports: master = player side, slave = RAM side.
interface note_playback_if #(
    parameter int ADDR_W = 8,
    parameter int KEY_W  = 7,
    parameter int LEN_W  = 16
);
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [KEY_W+LEN_W-1:0]  rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/hold_counter.sv
// rtl/hold_counter.sv - per-record hold counter: load, decrement on tick, expire flag
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   clear        force counter to 0 (playback stopped)
//   load         load load_val (takes priority over counting)
//   load_val     hold length in tempo ticks
//   en           counting enabled (player is holding a note)
//   tick         tempo strobe
//   expire       tick arriving while the last tick of the hold is pending
module hold_counter #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             en,
    input  logic             tick,
    output logic             expire
);
    logic [LEN_W-1:0] hold;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            hold <= '0;
        end else if (load) begin
            hold <= load_val;
        end else if (en && tick && hold != '0) begin
            hold <= hold - 1'b1;
        end
    end

    assign expire = en && tick && (hold == LEN_W'(1));
endmodule

// File: rtl/note_playback.sv
// rtl/note_playback.sv - buzzer track playback engine (records -> one note per cycle)
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   play         level: 1 = play track, 0 = stop
//   tick         tempo strobe; hold counters advance only on tick
//   rec_count    records in RAM, latched when playback starts
//   ram          record RAM read port (master modport)
//   key          current note to the buzzer (0 = silence)
//   playing      1 while fetching/loading/holding
//   done         one-cycle pulse at end of track
// Build option: PLAYBACK_LOOP_EN - wrap to record 0 at end of track instead of finishing.
module note_playback #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16,
    parameter int KEY_W  = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              play,
    input  logic              tick,
    input  logic [ADDR_W:0]   rec_count,
    note_playback_if.master   ram,
    output logic [KEY_W-1:0]  key,
    output logic              playing,
    output logic              done
);
    import beat_pkg::*;

    localparam logic [ADDR_W:0] MAX_RECS = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    logic [ADDR_W:0] n;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_next;
    logic            last_rec;
    logic            expire;
    logic            end_of_rec;
    logic            hc_load;

    logic [KEY_W-1:0] rec_key;
    logic [LEN_W-1:0] rec_len;

    assign rec_key  = ram.rd_data[KEY_W+LEN_W-1:LEN_W];
    assign rec_len  = ram.rd_data[LEN_W-1:0];
    assign idx_next = idx + 1'b1;
    assign last_rec = (idx_next == n);

    assign hc_load    = (state == LOAD) && (rec_len != '0);
    // A zero-length record ends the moment it is loaded, so it never reaches the buzzer.
    assign end_of_rec = ((state == LOAD) && (rec_len == '0)) || expire;

    hold_counter #(.LEN_W(LEN_W)) u_hold (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (!play),
        .load     (hc_load),
        .load_val (rec_len),
        .en       (state == HOLD),
        .tick     (tick),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            key         <= KEY_SILENCE;
            ram.rd_en   <= 1'b0;
            ram.rd_addr <= '0;
            playing     <= 1'b0;
            done        <= 1'b0;
            idx         <= '0;
            n           <= '0;
        end else begin
            done      <= 1'b0;
            ram.rd_en <= 1'b0;
            if (!play) begin
                state   <= IDLE;
                key     <= KEY_SILENCE;
                playing <= 1'b0;
                idx     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        key <= KEY_SILENCE;
                        if (rec_count != '0) begin
                            n           <= (rec_count > MAX_RECS) ? MAX_RECS : rec_count;
                            idx         <= '0;
                            ram.rd_en   <= 1'b1;
                            ram.rd_addr <= '0;
                            playing     <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        if (rec_len != '0) begin
                            key   <= rec_key;
                            state <= HOLD;
                        end
                    end
                    HOLD: ;
                    DONE: begin
                        key     <= KEY_SILENCE;
                        playing <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase

                // Record finished: the previous key stays on the buzzer through the next fetch.
                if (end_of_rec) begin
                    if (!last_rec) begin
                        idx         <= idx_next;
                        ram.rd_en   <= 1'b1;
                        ram.rd_addr <= idx_next[ADDR_W-1:0];
                        state       <= FETCH;
                    end else begin
`ifdef PLAYBACK_LOOP_EN
                        idx         <= '0;
                        ram.rd_en   <= 1'b1;
                        ram.rd_addr <= '0;
                        state       <= FETCH;
`else
                        done    <= 1'b1;
                        key     <= KEY_SILENCE;
                        playing <= 1'b0;
                        state   <= DONE;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_note_playback.sv
// tb/tb_note_playback.sv - self-checking bench for note_playback against a record-level model
module tb_note_playback;
    localparam int AW   = 3;
    localparam int KW   = 7;
    localparam int LW   = 16;
    localparam int NREC = 8;
    localparam int LMAX = 200;
`ifdef PLAYBACK_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          play;
    logic          tick;
    logic [AW:0]   rec_count;
    logic [KW-1:0] key;
    logic          playing;
    logic          done;

    note_playback_if #(.ADDR_W(AW), .KEY_W(KW), .LEN_W(LW)) ram ();

    note_playback #(.ADDR_W(AW), .LEN_W(LW), .KEY_W(KW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .play      (play),
        .tick      (tick),
        .rec_count (rec_count),
        .ram       (ram),
        .key       (key),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;

    beat_pkg::record_t mem [NREC];

    always @(posedge clk) begin
        if (ram.rd_en) ram.rd_data <= mem[ram.rd_addr];
    end

    int checks = 0;
    int errors = 0;

    logic          tk [LMAX];
    logic [KW-1:0] ek [LMAX];
    logic          ep [LMAX];
    logic          ed [LMAX];
    logic          er [LMAX];
    logic [AW-1:0] ea [LMAX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void set_exp(int c, logic [KW-1:0] k, logic p, logic d, logic r, logic [AW-1:0] a);
        if (c >= 0 && c < LMAX) begin
            ek[c] = k; ep[c] = p; ed[c] = d; er[c] = r; ea[c] = a;
        end
    endfunction

    // Expected outputs after each clock edge c (edge 0 samples play high), derived record by record:
    // fetch edge e, load edge e+2, then the len-th tick after the load edge ends the note.
    task automatic build(input int cnt, input int L, input bit lp);
        int n, i, e, x, rem, le, ende;
        logic [KW-1:0] cur;
        for (int c = 0; c < LMAX; c++) set_exp(c, '0, 1'b0, 1'b0, 1'b0, '0);
        n = (cnt > NREC) ? NREC : cnt;
        if (n == 0) begin
            set_exp(0, '0, 1'b0, 1'b1, 1'b0, '0);
            return;
        end
        i = 0; e = 0; cur = '0;
        while (e < L) begin
            set_exp(e, cur, 1'b1, 1'b0, 1'b1, AW'(i));
            set_exp(e + 1, cur, 1'b1, 1'b0, 1'b0, '0);
            le = e + 2;
            ende = le;
            if (mem[i].len != '0) begin
                cur = mem[i].key;
                set_exp(le, cur, 1'b1, 1'b0, 1'b0, '0);
                rem = int'(mem[i].len);
                x = le + 1;
                while (rem > 0 && x < L) begin
                    if (tk[x]) rem--;
                    if (rem == 0) ende = x;
                    else set_exp(x, cur, 1'b1, 1'b0, 1'b0, '0);
                    x++;
                end
                if (rem > 0) return;
            end
            if (i + 1 < n) i++;
            else if (lp) i = 0;
            else begin
                set_exp(ende, '0, 1'b0, 1'b1, 1'b0, '0);
                return;
            end
            e = ende;
        end
    endtask

    task automatic run(input string name, input int cnt, input int L);
        rec_count = AW'(0) + (AW+1)'(cnt);
        build(cnt, L, LOOP);
        for (int c = 0; c < L; c++) begin
            play = 1'b1;
            tick = tk[c];
            @(posedge clk);
            #1;
            check($sformatf("%s key c%0d", name, c), 32'(key), 32'(ek[c]));
            check($sformatf("%s playing c%0d", name, c), 32'(playing), 32'(ep[c]));
            check($sformatf("%s done c%0d", name, c), 32'(done), 32'(ed[c]));
            check($sformatf("%s rd_en c%0d", name, c), 32'(ram.rd_en), 32'(er[c]));
            if (er[c]) check($sformatf("%s rd_addr c%0d", name, c), 32'(ram.rd_addr), 32'(ea[c]));
            if (c == 1) rec_count = (AW+1)'($urandom_range(0, 15));
        end
        play = 1'b0;
        tick = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("%s stop key", name), 32'(key), 32'd0);
        check($sformatf("%s stop playing", name), 32'(playing), 32'd0);
        check($sformatf("%s stop rd_en", name), 32'(ram.rd_en), 32'd0);
        check($sformatf("%s stop done", name), 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic beat_pkg::record_t rec(int k, int len);
        beat_pkg::record_t r;
        r.key = KW'(k);
        r.len = LW'(len);
        return r;
    endfunction

    task automatic all_ticks();
        for (int c = 0; c < LMAX; c++) tk[c] = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        play = 1'b1;
        tick = 1'b0;
        rec_count = 4'd2;
        for (int i = 0; i < NREC; i++) mem[i] = rec(8'h61 + i, 1);

        // Reset held with play high: outputs stay quiet
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("reset key", 32'(key), 32'd0);
            check("reset rd_en", 32'(ram.rd_en), 32'd0);
            check("reset playing", 32'(playing), 32'd0);
            check("reset done", 32'(done), 32'd0);
        end
        play = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Two records, tick every cycle
        all_ticks();
        mem[0] = rec(8'h61, 3);
        mem[1] = rec(8'h62, 1);
        run("two_rec", 2, 16);

        // Zero-length record in the middle is skipped
        mem[0] = rec(8'h61, 2);
        mem[1] = rec(8'h63, 0);
        mem[2] = rec(8'h64, 2);
        run("skip_zero", 3, 16);

        // Empty track
        run("empty", 0, 5);

        // Stop mid-hold, then restart from record 0
        mem[0] = rec(8'h61, 5);
        run("stop_mid", 1, 5);
        run("restart", 1, 12);

        // Two-note track, long run (wraps when looping)
        mem[0] = rec(8'h61, 2);
        mem[1] = rec(8'h62, 2);
        run("wrap", 2, 30);

        // rec_count beyond RAM size is clamped
        for (int i = 0; i < NREC; i++) mem[i] = rec(8'h41 + i, 1);
        run("clamp", 15, 40);

        // Randomized tracks and tempo
        for (int t = 0; t < 20; t++) begin
            int dens;
            dens = $urandom_range(30, 100);
            for (int i = 0; i < NREC; i++)
                mem[i] = rec($urandom_range(1, 127), $urandom_range(0, 3));
            for (int c = 0; c < LMAX; c++) tk[c] = ($urandom_range(0, 99) < dens);
            run($sformatf("rand%0d", t), $urandom_range(0, 15), 120);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
